ewrapper_emesh_tx_arbiter: RTL and testbench

//  Shares the single emesh transmit port of ewrapper_link_transmitter (emesh_*_outb) between NREQ requesters.
//  - Each requester owns a one-entry holding buffer and its own wait output.
//  - A round-robin arbiter drains the buffers onto the link.
//  - A buffered write is held back while the link raises wr_wait; a buffered read is held back while it raises rd_wait.
//  - Sits between the fabric-side emesh masters and ctrl_tx, in the emesh_clk_inb domain.

---
 rtl/ewrapper_emesh_tx_arbiter_pkg.sv | 52 +++++
 rtl/ewrapper_emesh_tx_arbiter_if.sv | 50 +++++
 rtl/ewrapper_emesh_tx_arbiter_rr_arbiter.sv | 63 ++++++
 rtl/ewrapper_emesh_tx_arbiter.sv | 109 ++++++++++
 tb/tb_ewrapper_emesh_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ewrapper_emesh_tx_arbiter_pkg.sv
// ewrapper_emesh_tx_arbiter_pkg
//   Shared definitions for the emesh transmit arbiter: the packed
//   transaction width, the bit offset of each field inside a packed
//   transaction, a field-level struct view, and helpers that convert
//   between the raw vector and the struct.
//   Packed layout, MSB first: {write, datamode[1:0], ctrlmode[3:0],
//   dstaddr[31:0], srcaddr[31:0], data[31:0]}.
package ewrapper_emesh_tx_arbiter_pkg;

  localparam int PKT_W     = 103;
  localparam int PKT_DATA  = 0;
  localparam int PKT_SRC   = 32;
  localparam int PKT_DST   = 64;
  localparam int PKT_CMODE = 96;
  localparam int PKT_DMODE = 100;
  localparam int PKT_WRITE = 102;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } emesh_pkt_t;

  // Split a raw packed transaction into its named fields.
  function automatic emesh_pkt_t pkt_unpack(input logic [PKT_W-1:0] raw);
    emesh_pkt_t p;
    p.write    = raw[PKT_WRITE];
    p.datamode = raw[PKT_DMODE +: 2];
    p.ctrlmode = raw[PKT_CMODE +: 4];
    p.dstaddr  = raw[PKT_DST +: 32];
    p.srcaddr  = raw[PKT_SRC +: 32];
    p.data     = raw[PKT_DATA +: 32];
    return p;
  endfunction

  // Build a raw packed transaction from named fields.
  function automatic logic [PKT_W-1:0] pkt_pack(input emesh_pkt_t p);
    logic [PKT_W-1:0] raw;
    raw                  = '0;
    raw[PKT_WRITE]       = p.write;
    raw[PKT_DMODE +: 2]  = p.datamode;
    raw[PKT_CMODE +: 4]  = p.ctrlmode;
    raw[PKT_DST +: 32]   = p.dstaddr;
    raw[PKT_SRC +: 32]   = p.srcaddr;
    raw[PKT_DATA +: 32]  = p.data;
    return raw;
  endfunction

endpackage

// File: rtl/ewrapper_emesh_tx_arbiter_if.sv
// ewrapper_emesh_tx_arbiter_if
//   The emesh transmit link between the arbiter and the link transmitter.
//   master : arbiter side, drives the transaction and observes the waits
//   slave  : transmitter side, consumes the transaction and drives the waits
//   emesh_access_outb    transaction valid this cycle
//   emesh_write_outb     1 = write, 0 = read
//   emesh_datamode_outb  2-bit data mode
//   emesh_ctrlmode_outb  4-bit control mode
//   emesh_dstaddr_outb   destination address
//   emesh_srcaddr_outb   source address
//   emesh_data_outb      write data
//   emesh_wr_wait_inb    writes are blocked this cycle
//   emesh_rd_wait_inb    reads are blocked this cycle
interface ewrapper_emesh_tx_arbiter_if;

  logic        emesh_access_outb;
  logic        emesh_write_outb;
  logic [1:0]  emesh_datamode_outb;
  logic [3:0]  emesh_ctrlmode_outb;
  logic [31:0] emesh_dstaddr_outb;
  logic [31:0] emesh_srcaddr_outb;
  logic [31:0] emesh_data_outb;
  logic        emesh_wr_wait_inb;
  logic        emesh_rd_wait_inb;

  modport master (
    output emesh_access_outb,
    output emesh_write_outb,
    output emesh_datamode_outb,
    output emesh_ctrlmode_outb,
    output emesh_dstaddr_outb,
    output emesh_srcaddr_outb,
    output emesh_data_outb,
    input  emesh_wr_wait_inb,
    input  emesh_rd_wait_inb
  );

  modport slave (
    input  emesh_access_outb,
    input  emesh_write_outb,
    input  emesh_datamode_outb,
    input  emesh_ctrlmode_outb,
    input  emesh_dstaddr_outb,
    input  emesh_srcaddr_outb,
    input  emesh_data_outb,
    output emesh_wr_wait_inb,
    output emesh_rd_wait_inb
  );

endinterface

// File: rtl/ewrapper_emesh_tx_arbiter_rr_arbiter.sv
// ewrapper_rr_arbiter
//   Round-robin arbiter with a combinational grant. The search starts at
//   the pointer and wraps modulo NREQ; requesters that are not asking are
//   simply skipped, so one stalled requester never blocks the others.
//   When a grant is taken (advance=1) the pointer moves to the entry just
//   after the winner, which gives that winner lowest priority next time.
//   Ports:
//     clk        clock
//     reset      asynchronous active-low reset (pointer returns to 0)
//     req        per-requester request (already qualified by the caller)
//     advance    1 = the current grant is consumed at this edge
//     grant      one-hot grant, all zero when nobody requests
//     any_grant  OR of grant
module ewrapper_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic            any_grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] gnt_idx_s;

  // Scan from ptr upward with wrap; the first requesting entry wins.
  always_comb begin
    int   idx;
    logic hit_s;
    idx       = 0;
    hit_s     = 1'b0;
    grant     = '0;
    any_grant = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx        = (int'(ptr_r) + k) % NREQ;
      hit_s      = ~any_grant & req[idx];
      grant[idx] = hit_s;
      gnt_idx_s  = hit_s ? PTR_W'(idx) : gnt_idx_s;
      any_grant  = any_grant | hit_s;
    end
  end

  // Pointer update: one past the winner, wrapping at NREQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (advance && any_grant) begin
      if (int'(gnt_idx_s) == NREQ - 1) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ewrapper_emesh_tx_arbiter.sv
// ewrapper_emesh_tx_arbiter
//   Shares the single emesh transmit port between NREQ requesters. Each
//   requester owns a one-entry holding buffer; a round-robin arbiter
//   drains the buffers onto the link. Buffered writes are held while the
//   link raises wr_wait, buffered reads while it raises rd_wait, and the
//   two types never block each other.
//   Ports:
//     clk           emesh clock, the only clock of the block
//     reset         asynchronous active-low reset; drops buffered work
//     req_access    per-requester access strobe
//     req_packet    packed transactions, slice i belongs to requester i
//     req_wait      per-requester buffer-full indication (registered)
//     err_overflow  sticky: an access arrived while the buffer was full
//     tx            emesh link, master side (transaction out, waits in)
module ewrapper_emesh_tx_arbiter
  import ewrapper_emesh_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_access,
  input  logic [NREQ*PKT_W-1:0] req_packet,
  output logic [NREQ-1:0]       req_wait,
  output logic [NREQ-1:0]       err_overflow,
  ewrapper_emesh_tx_arbiter_if.master tx
);

  logic [PKT_W-1:0] buf_r [NREQ];
  logic [NREQ-1:0]  valid_r;
  logic [NREQ-1:0]  err_r;

  logic [NREQ-1:0]  elig_s;
  logic [NREQ-1:0]  grant_s;
  logic             any_grant_s;
  logic [PKT_W-1:0] out_raw_s;
  emesh_pkt_t       out_pkt_s;

  // Eligibility: a buffered entry is blocked only by the wait of its own type.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = valid_r[i] &
                  (buf_r[i][PKT_WRITE] ? ~tx.emesh_wr_wait_inb
                                       : ~tx.emesh_rd_wait_inb);
    end
  end

  ewrapper_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (elig_s),
    .advance   (1'b1),
    .grant     (grant_s),
    .any_grant (any_grant_s)
  );

  // Output mux: grant is one-hot, so an AND-OR select yields zero with no grant.
  always_comb begin
    out_raw_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      out_raw_s = out_raw_s | (buf_r[i] & {PKT_W{grant_s[i]}});
    end
  end

  assign out_pkt_s              = pkt_unpack(out_raw_s);
  assign tx.emesh_access_outb   = any_grant_s;
  assign tx.emesh_write_outb    = out_pkt_s.write;
  assign tx.emesh_datamode_outb = out_pkt_s.datamode;
  assign tx.emesh_ctrlmode_outb = out_pkt_s.ctrlmode;
  assign tx.emesh_dstaddr_outb  = out_pkt_s.dstaddr;
  assign tx.emesh_srcaddr_outb  = out_pkt_s.srcaddr;
  assign tx.emesh_data_outb     = out_pkt_s.data;

  // Holding buffers and sticky overflow flags. A buffer drained this cycle
  // may be refilled at the same edge, which is not an overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      err_r   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_access[i] && (!valid_r[i] || grant_s[i])) begin
          buf_r[i]   <= req_packet[i*PKT_W +: PKT_W];
          valid_r[i] <= 1'b1;
        end else if (grant_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end

        if (req_access[i] && valid_r[i] && !grant_s[i]) begin
          err_r[i] <= 1'b1;
        end else begin
          err_r[i] <= err_r[i];
        end
      end
    end
  end

  assign req_wait     = valid_r;
  assign err_overflow = err_r;

endmodule

// File: tb/tb_ewrapper_emesh_tx_arbiter.sv
// tb_ewrapper_emesh_tx_arbiter
//   Randomized and directed stimulus against a cycle-level reference model.
//   The model queues each transaction it expects on the link; a separate
//   monitor pops and compares whenever the DUT presents one.
module tb_ewrapper_emesh_tx_arbiter;

  localparam int NREQ = 2;
  localparam int PW   = 103;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_access;
  logic [NREQ*PW-1:0] req_packet;
  logic [NREQ-1:0]   req_wait;
  logic [NREQ-1:0]   err_overflow;

  ewrapper_emesh_tx_arbiter_if tx_if();

  ewrapper_emesh_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_access   (req_access),
    .req_packet   (req_packet),
    .req_wait     (req_wait),
    .err_overflow (err_overflow),
    .tx           (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic w, input logic [31:0] dst, input logic [31:0] data);
    logic [PW-1:0] p;
    p = {w, 2'($urandom), 4'($urandom), dst, 32'($urandom), data};
    return p;
  endfunction

  function automatic logic [PW-1:0] rnd_pkt();
    return mk_pkt(1'($urandom), 32'($urandom), 32'($urandom));
  endfunction

  function automatic logic [PW-1:0] dut_pkt();
    return {tx_if.emesh_write_outb, tx_if.emesh_datamode_outb, tx_if.emesh_ctrlmode_outb,
            tx_if.emesh_dstaddr_outb, tx_if.emesh_srcaddr_outb, tx_if.emesh_data_outb};
  endfunction

  // ---------------- reference model ----------------
  logic [PW-1:0]   m_pkt [NREQ];
  logic [NREQ-1:0] m_full;
  logic [NREQ-1:0] m_err;
  int              m_ptr;
  logic [PW-1:0]   exp_q [$];

  initial begin
    m_full = '0;
    m_err  = '0;
    m_ptr  = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        m_full = '0;
        m_err  = '0;
        m_ptr  = 0;
        check("rst_req_wait", 128'(req_wait), 128'(0));
        check("rst_err", 128'(err_overflow), 128'(0));
      end else begin
        int winner;
        check("req_wait", 128'(req_wait), 128'(m_full));
        check("err_overflow", 128'(err_overflow), 128'(m_err));
        // round-robin: first full, unblocked entry at or after m_ptr
        winner = -1;
        for (int k = 0; k < NREQ; k++) begin
          int n;
          logic blocked;
          n = (m_ptr + k) % NREQ;
          blocked = m_pkt[n][PW-1] ? tx_if.emesh_wr_wait_inb : tx_if.emesh_rd_wait_inb;
          if (winner < 0 && m_full[n] && !blocked) winner = n;
        end
        if (winner >= 0) begin
          exp_q.push_back(m_pkt[winner]);
          m_ptr = (winner + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (winner == i) m_full[i] = 1'b0;
          if (req_access[i]) begin
            if (m_full[i]) begin
              m_err[i] = 1'b1;
            end else begin
              m_pkt[i]  = req_packet[i*PW +: PW];
              m_full[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (tx_if.emesh_access_outb === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL link_unexpected: got access=1 pkt=%0h, required no transaction", dut_pkt());
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          check("link_pkt", 128'(dut_pkt()), 128'(e));
        end
      end else begin
        check("idle_fields", 128'(dut_pkt()), 128'(0));
      end
      check("link_sync", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [1:0] a, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input logic wr, input logic rd);
    req_access              = a;
    req_packet              = {p1, p0};
    tx_if.emesh_wr_wait_inb = wr;
    tx_if.emesh_rd_wait_inb = rd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] pa, pb, pz;

  initial begin
    pz = '0;
    reset = 1'b0;
    req_access = '0;
    req_packet = '0;
    tx_if.emesh_wr_wait_inb = 1'b0;
    tx_if.emesh_rd_wait_inb = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      set_in(2'b00, pz, pz, 1'b0, 1'b0);
      check("t1_access", 128'(tx_if.emesh_access_outb), 128'(0));
      check("t1_wait", 128'(req_wait), 128'(0));
      step();
    end

    // single write, one-cycle latency
    pa = mk_pkt(1'b1, 32'h8080_0000, 32'hDEAD_BEEF);
    set_in(2'b01, pa, pz, 1'b0, 1'b0);
    step();
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t2_access", 128'(tx_if.emesh_access_outb), 128'(1));
    check("t2_dst", 128'(tx_if.emesh_dstaddr_outb), 128'(32'h8080_0000));
    check("t2_data", 128'(tx_if.emesh_data_outb), 128'(32'hDEAD_BEEF));
    check("t2_wait", 128'(req_wait), 128'(2'b01));
    step();
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t2_access_after", 128'(tx_if.emesh_access_outb), 128'(0));
    check("t2_wait_after", 128'(req_wait), 128'(0));
    step();

    // contention
    for (int r = 0; r < 8; r++) begin
      set_in(2'b11, rnd_pkt(), rnd_pkt(), 1'b0, 1'b0);
      step();
      set_in(2'b00, pz, pz, 1'b0, 1'b0);
      step();
    end
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    step();

    // wait split: write blocked, read flows
    pa = mk_pkt(1'b1, 32'h1000_0000, 32'h1111_1111);
    pb = mk_pkt(1'b0, 32'h2000_0000, 32'h2222_2222);
    set_in(2'b11, pa, pb, 1'b1, 1'b0);
    step();
    set_in(2'b00, pz, pz, 1'b1, 1'b0);
    check("t4_read_access", 128'(tx_if.emesh_access_outb), 128'(1));
    check("t4_read_write", 128'(tx_if.emesh_write_outb), 128'(0));
    check("t4_read_data", 128'(tx_if.emesh_data_outb), 128'(32'h2222_2222));
    step();
    for (int c = 0; c < 18; c++) begin
      set_in(2'b00, pz, pz, 1'b1, 1'b0);
      check("t4_held_access", 128'(tx_if.emesh_access_outb), 128'(0));
      check("t4_held_wait", 128'(req_wait[0]), 128'(1));
      step();
    end
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t4_write_access", 128'(tx_if.emesh_access_outb), 128'(1));
    check("t4_write_data", 128'(tx_if.emesh_data_outb), 128'(32'h1111_1111));
    step();

    // overflow
    pa = mk_pkt(1'b1, 32'h3000_0000, 32'h3333_3333);
    pb = mk_pkt(1'b1, 32'h4000_0000, 32'h4444_4444);
    set_in(2'b01, pa, pz, 1'b1, 1'b0);
    step();
    set_in(2'b01, pb, pz, 1'b1, 1'b0);
    step();
    set_in(2'b00, pz, pz, 1'b1, 1'b0);
    check("t5_err", 128'(err_overflow), 128'(2'b01));
    check("t5_held", 128'(tx_if.emesh_access_outb), 128'(0));
    step();
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t5_issue_access", 128'(tx_if.emesh_access_outb), 128'(1));
    check("t5_issue_data", 128'(tx_if.emesh_data_outb), 128'(32'h3333_3333));
    step();
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t5_dropped", 128'(tx_if.emesh_access_outb), 128'(0));
    check("t5_err_sticky", 128'(err_overflow), 128'(2'b01));
    step();

    // async reset with both buffers full
    set_in(2'b11, mk_pkt(1'b1, 32'h5, 32'h5), mk_pkt(1'b1, 32'h6, 32'h6), 1'b1, 1'b1);
    step();
    set_in(2'b00, pz, pz, 1'b0, 1'b0);
    check("t6_pre_wait", 128'(req_wait), 128'(2'b11));
    reset = 1'b0;
    #1;
    check("t6_rst_access", 128'(tx_if.emesh_access_outb), 128'(0));
    check("t6_rst_wait", 128'(req_wait), 128'(0));
    check("t6_rst_err", 128'(err_overflow), 128'(0));
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_in(2'b00, pz, pz, 1'b0, 1'b0);
      check("t6_no_issue", 128'(tx_if.emesh_access_outb), 128'(0));
      step();
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      logic [1:0] a;
      for (int i = 0; i < NREQ; i++) begin
        if (req_wait[i]) a[i] = ($urandom % 20) == 0;
        else             a[i] = ($urandom % 3) != 0;
      end
      set_in(a, rnd_pkt(), rnd_pkt(), ($urandom % 4) == 0, ($urandom % 4) == 0);
      step();
    end
    for (int c = 0; c < 5; c++) begin
      set_in(2'b00, pz, pz, 1'b0, 1'b0);
      step();
    end
    check("final_drained", 128'(req_wait), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
